// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Arbitrates I-cache and D-cache line requests onto one shared slow
//           memory port. Define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//           the default is fixed priority, with D winning over I.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction cache
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    // data cache
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    // shared memory
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_I  = 2'd1,
        S_BUSY_D  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    logic                pend_i;
    logic                pend_d;
    logic                grant_data;
    logic                busy_i;
    logic                busy_d;

    assign pend_i = i_read | i_write;
    assign pend_d = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the data cache received the most recent grant.
    logic last_d_q;
    assign grant_data = pend_d & (~pend_i | ~last_d_q);
`else
    assign grant_data = pend_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_i | pend_d) begin
                        if (grant_data) begin
                            mem_read_q  <= d_read;
                            mem_write_q <= d_write;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            state_q     <= S_BUSY_D;
                        end else begin
                            mem_read_q  <= i_read;
                            mem_write_q <= i_write;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= i_wdata;
                            state_q     <= S_BUSY_I;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q <= grant_data;
`endif
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= S_RELEASE;
                    end
                end
                // One dead cycle lets the served cache drop its request first.
                S_RELEASE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps ready/rdata quiet while reset is being applied.
    assign busy_i = rst_n && (state_q == S_BUSY_I);
    assign busy_d = rst_n && (state_q == S_BUSY_D);

    assign i_ready   = busy_i & mem_ready;
    assign d_ready   = busy_d & mem_ready;
    assign i_rdata   = busy_i ? mem_rdata : '0;
    assign d_rdata   = busy_d ? mem_rdata : '0;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter: directed vector table, a
//           mid-transaction reset sequence and random transactions vs a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, mem_ready;

    int total = 0;
    int bad   = 0;
    bit m_last_d;   // model: data cache received the latest grant

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic              ir, iw, dr, dw;
        logic [ADDR_W-1:0] ia, da;
        logic [LINE_W-1:0] iwd, dwd;
        int                lat;
        int                win;   // 0 none, 1 I, 2 D
        bit                hold;
        bit                spur;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkw(nm, LINE_W'(act), LINE_W'(exp));
    endtask

    function automatic int model_pick(input logic ip, input logic dp);
        if (!ip && !dp) return 0;
        if (!ip)        return 2;
        if (!dp)        return 1;
        if (RR)         return m_last_d ? 1 : 2;
        return 2;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction: IDLE sample, BUSY for v.lat cycles, RELEASE.
    task automatic do_txn(input vec_t v, input string nm);
        logic              er, ew;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ewd;
        tick();
        i_read = v.ir; i_write = v.iw; i_addr = v.ia; i_wdata = v.iwd;
        d_read = v.dr; d_write = v.dw; d_addr = v.da; d_wdata = v.dwd;
        mem_ready = v.spur; mem_rdata = rnd_line();
        @(negedge clk);
        chk1({nm, "/idle_rd"}, mem_read, 1'b0);
        chk1({nm, "/idle_wr"}, mem_write, 1'b0);
        chk1({nm, "/idle_irdy"}, i_ready, 1'b0);
        chk1({nm, "/idle_drdy"}, d_ready, 1'b0);
        if (v.win == 0) begin
            mem_ready = 1'b0;
            return;
        end
        er  = (v.win == 2) ? v.dr  : v.ir;
        ew  = (v.win == 2) ? v.dw  : v.iw;
        ea  = (v.win == 2) ? v.da  : v.ia;
        ewd = (v.win == 2) ? v.dwd : v.iwd;
        m_last_d = (v.win == 2);
        for (int c = 1; c <= v.lat; c++) begin
            tick();
            mem_ready = (c == v.lat);
            mem_rdata = rnd_line();
            @(negedge clk);
            chk1({nm, "/busy_rd"}, mem_read, er);
            chk1({nm, "/busy_wr"}, mem_write, ew);
            chkw({nm, "/busy_addr"}, LINE_W'(mem_addr), LINE_W'(ea));
            chkw({nm, "/busy_wdata"}, mem_wdata, ewd);
            chk1({nm, "/busy_irdy"}, i_ready, (v.win == 1) && (c == v.lat));
            chk1({nm, "/busy_drdy"}, d_ready, (v.win == 2) && (c == v.lat));
            chkw({nm, "/busy_irdata"}, i_rdata, (v.win == 1) ? mem_rdata : '0);
            chkw({nm, "/busy_drdata"}, d_rdata, (v.win == 2) ? mem_rdata : '0);
        end
        tick();
        mem_ready = v.spur;
        mem_rdata = rnd_line();
        if (!v.hold) begin
            if (v.win == 2) begin d_read = 1'b0; d_write = 1'b0; end
            else            begin i_read = 1'b0; i_write = 1'b0; end
        end
        @(negedge clk);
        chk1({nm, "/rel_rd"}, mem_read, 1'b0);
        chk1({nm, "/rel_wr"}, mem_write, 1'b0);
        chk1({nm, "/rel_irdy"}, i_ready, 1'b0);
        chk1({nm, "/rel_drdy"}, d_ready, 1'b0);
        chkw({nm, "/rel_irdata"}, i_rdata, '0);
        chkw({nm, "/rel_drdata"}, d_rdata, '0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        mem_ready = 1'b1; mem_rdata = '1;
        m_last_d = 1'b0;

        // Table: inputs and expected winner. Row order drives the RR pointer.
        foreach (vt[k]) begin
            vt[k].ir = 0; vt[k].iw = 0; vt[k].dr = 0; vt[k].dw = 0;
            vt[k].ia = '0; vt[k].da = '0; vt[k].iwd = '0; vt[k].dwd = '0;
            vt[k].lat = 2; vt[k].win = 0; vt[k].hold = 0; vt[k].spur = 0;
        end
        vt[0].dw = 1; vt[0].da = 28'hFFFFFFF; vt[0].dwd = '1; vt[0].lat = 3; vt[0].win = 2;
        vt[1].ir = 1; vt[1].ia = 28'h0000010; vt[1].lat = 4; vt[1].win = 1;
        vt[2].ir = 1; vt[2].dw = 1; vt[2].ia = 28'h0000123; vt[2].da = 28'h0ABCDEF;
        vt[2].dwd = 128'h0123456789ABCDEF_FEDCBA9876543210; vt[2].win = 2; vt[2].spur = 1;
        vt[3].iw = 1; vt[3].dr = 1; vt[3].ia = 28'h0000456; vt[3].da = 28'h0000789;
        vt[3].iwd = 128'h5A5A; vt[3].lat = 3; vt[3].win = RR ? 1 : 2;
        vt[4].ir = 1; vt[4].iw = 1; vt[4].ia = 28'h1234567; vt[4].iwd = 128'hC0FFEE; vt[4].lat = 1; vt[4].win = 1;
        vt[5].dr = 1; vt[5].da = 28'h0000042; vt[5].win = 2; vt[5].hold = 1;
        vt[6].dr = 1; vt[6].da = 28'h0000042; vt[6].win = 2; vt[6].lat = 5;
        vt[7].win = 0; vt[7].spur = 1;

        // Reset state, with mem_ready high during reset.
        tick();
        @(negedge clk);
        chk1("rst_irdy", i_ready, 1'b0);
        chk1("rst_drdy", d_ready, 1'b0);
        chkw("rst_irdata", i_rdata, '0);
        chkw("rst_drdata", d_rdata, '0);
        chk1("rst_rd", mem_read, 1'b0);
        chk1("rst_wr", mem_write, 1'b0);
        chkw("rst_addr", LINE_W'(mem_addr), '0);
        chkw("rst_wdata", mem_wdata, '0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b0;

        foreach (vt[k]) do_txn(vt[k], $sformatf("vec%0d", k));

        // Reset in the middle of a data-cache write, then a stray mem_ready.
        tick();
        d_write = 1; d_addr = 28'h0000ABC; d_wdata = 128'hDEAD;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk1("midrst_busy_wr", mem_write, 1'b1);
        tick();
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk1("midrst_in_drdy", d_ready, 1'b0);
        chkw("midrst_in_drdata", d_rdata, '0);
        tick();
        rst_n = 1'b1; d_write = 0; mem_ready = 1'b1;
        @(negedge clk);
        chk1("midrst_drdy", d_ready, 1'b0);
        chk1("midrst_irdy", i_ready, 1'b0);
        chk1("midrst_rd", mem_read, 1'b0);
        chk1("midrst_wr", mem_write, 1'b0);
        chkw("midrst_addr", LINE_W'(mem_addr), '0);
        chkw("midrst_wdata", mem_wdata, '0);
        tick();
        mem_ready = 1'b0;
        m_last_d = 1'b0;

        // Random transactions; expected winner from the policy model.
        for (int n = 0; n < 40; n++) begin
            v.ir = 1'($urandom); v.iw = 1'($urandom);
            v.dr = 1'($urandom); v.dw = 1'($urandom);
            v.ia = ADDR_W'($urandom); v.da = ADDR_W'($urandom);
            v.iwd = rnd_line(); v.dwd = rnd_line();
            v.lat = int'($urandom_range(1, 5));
            v.hold = 1'($urandom); v.spur = 1'($urandom);
            v.win = model_pick(v.ir | v.iw, v.dr | v.dw);
            do_txn(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
